// File: rtl/shifter11_pkg.sv
// shifter11_pkg: shared widths and types for the 11-bit triple shifter.
// Imported by shifter11_stage and shifter11_unit.
package shifter11_pkg;

    localparam int WIDTH   = 11;
    localparam int SHAMT_W = 4;
    localparam int NSTAGE  = SHAMT_W;

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        word_t ll;
        word_t rl;
        word_t ra;
    } result_t;

endpackage

// File: rtl/shifter11_stage.sv
// shifter11_stage: one conditional shift-by-2^K mux level.
// Vacated positions take the fill bit; bits shifted off the end are dropped.
module shifter11_stage
    import shifter11_pkg::*;
#(
    parameter int   K   = 0,
    parameter dir_e DIR = DIR_LEFT
) (
    input  word_t d,
    input  logic  en,
    input  logic  fill,
    output word_t q
);

    localparam int N = 1 << K;

    word_t sh;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (DIR == DIR_LEFT) begin : g_left
                if (i >= N) begin : g_src
                    assign sh[i] = d[i-N];
                end else begin : g_fill
                    assign sh[i] = fill;
                end
            end else begin : g_right
                if (i + N < WIDTH) begin : g_src
                    assign sh[i] = d[i+N];
                end else begin : g_fill
                    assign sh[i] = fill;
                end
            end
        end
    endgenerate

    assign q = en ? sh : d;

endmodule

// File: rtl/shifter11_unit.sv
// shifter11_unit: registered 11-bit logical-left/logical-right/arith-right shifter.
// Define SHIFTER11_ARITH_EN to make y_ra sign-extend from a[10]; default fill is 0.
module shifter11_unit
    import shifter11_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    input  word_t  a,
    input  shamt_t s,
    output logic   out_valid,
    output word_t  y_ll,
    output word_t  y_rl,
    output word_t  y_ra
);

    logic ra_fill;

`ifdef SHIFTER11_ARITH_EN
    assign ra_fill = a[WIDTH-1];
`else
    assign ra_fill = 1'b0;
`endif

    word_t ll_w [0:NSTAGE];
    word_t rl_w [0:NSTAGE];
    word_t ra_w [0:NSTAGE];

    assign ll_w[0] = a;
    assign rl_w[0] = a;
    assign ra_w[0] = a;

    genvar k;
    generate
        for (k = 0; k < NSTAGE; k++) begin : g_stage
            shifter11_stage #(
                .K   (k),
                .DIR (DIR_LEFT)
            ) u_ll (
                .d    (ll_w[k]),
                .en   (s[k]),
                .fill (1'b0),
                .q    (ll_w[k+1])
            );

            shifter11_stage #(
                .K   (k),
                .DIR (DIR_RIGHT)
            ) u_rl (
                .d    (rl_w[k]),
                .en   (s[k]),
                .fill (1'b0),
                .q    (rl_w[k+1])
            );

            shifter11_stage #(
                .K   (k),
                .DIR (DIR_RIGHT)
            ) u_ra (
                .d    (ra_w[k]),
                .en   (s[k]),
                .fill (ra_fill),
                .q    (ra_w[k+1])
            );
        end
    endgenerate

    // Results hold when no new operand is qualified; only out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_ll      <= '0;
            y_rl      <= '0;
            y_ra      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_ll <= ll_w[NSTAGE];
                y_rl <= rl_w[NSTAGE];
                y_ra <= ra_w[NSTAGE];
            end
        end
    end

endmodule

// File: tb/tb_shifter11_unit.sv
// tb_shifter11_unit: scoreboard bench for shifter11_unit.
// Builds with or without SHIFTER11_ARITH_EN; expectations follow the macro.
module tb_shifter11_unit;
    import shifter11_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   in_valid;
    word_t  a;
    shamt_t s;
    logic   out_valid;
    word_t  y_ll;
    word_t  y_rl;
    word_t  y_ra;

    int vectors;
    int miscompares;

    result_t sb_q[$];
    result_t last_exp;

`ifdef SHIFTER11_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    shifter11_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .s         (s),
        .out_valid (out_valid),
        .y_ll      (y_ll),
        .y_rl      (y_rl),
        .y_ra      (y_ra)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic result_t model(input word_t av, input shamt_t sv);
        result_t r;
        logic signed [WIDTH-1:0] sa;
        r.ll = av << sv;
        r.rl = av >> sv;
        sa   = av;
        if (ARITH) r.ra = sa >>> sv;
        else       r.ra = av >> sv;
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input word_t av, input shamt_t sv);
        @(negedge clk);
        in_valid = v;
        a        = av;
        s        = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        s        = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || y_ll !== '0 || y_rl !== '0 || y_ra !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b ll=%h rl=%h ra=%h, required v=0 ll=rl=ra=000",
                     out_valid, y_ll, y_rl, y_ra);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        word_t  ta  [5] = '{11'h5A5, 11'h400, 11'h7FF, 11'h3FF, 11'h001};
        shamt_t ts  [5] = '{4'd0, 4'd4, 4'd15, 4'd11, 4'd10};
        word_t  tll [5] = '{11'h5A5, 11'h000, 11'h000, 11'h000, 11'h400};
        word_t  trl [5] = '{11'h5A5, 11'h040, 11'h000, 11'h000, 11'h000};
        word_t  tra1[5] = '{11'h5A5, 11'h7C0, 11'h7FF, 11'h000, 11'h000};
        word_t  tra0[5] = '{11'h5A5, 11'h040, 11'h000, 11'h000, 11'h000};
        result_t e;
        for (int i = 0; i < 5; i++) begin
            e.ll = tll[i];
            e.rl = trl[i];
            e.ra = ARITH ? tra1[i] : tra0[i];
            sb_q.push_back(e);
            drive_cycle(1'b1, ta[i], ts[i]);
            e = sb_q.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || y_ll !== e.ll || y_rl !== e.rl || y_ra !== e.ra) begin
                miscompares++;
                $display("FAIL directed_%0d a=%h s=%0d: got v=%b ll=%h rl=%h ra=%h, required v=1 ll=%h rl=%h ra=%h",
                         i, ta[i], ts[i], out_valid, y_ll, y_rl, y_ra, e.ll, e.rl, e.ra);
            end
        end
    endtask

    task automatic test_back_to_back();
        shamt_t ts [3] = '{4'd3, 4'd5, 4'd10};
        word_t  tll[3] = '{11'h008, 11'h020, 11'h400};
        result_t e;
        for (int i = 0; i < 3; i++) begin
            e.ll = tll[i];
            e.rl = 11'h000;
            e.ra = 11'h000;
            sb_q.push_back(e);
            drive_cycle(1'b1, 11'h001, ts[i]);
            e = sb_q.pop_front();
            last_exp = e;
            vectors++;
            if (out_valid !== 1'b1 || y_ll !== e.ll || y_rl !== e.rl || y_ra !== e.ra) begin
                miscompares++;
                $display("FAIL b2b_%0d s=%0d: got v=%b ll=%h rl=%h ra=%h, required v=1 ll=%h rl=%h ra=%h",
                         i, ts[i], out_valid, y_ll, y_rl, y_ra, e.ll, e.rl, e.ra);
            end
        end
        drive_cycle(1'b0, 11'h7FF, 4'd1);
        vectors++;
        if (out_valid !== 1'b0 || y_ll !== last_exp.ll || y_rl !== last_exp.rl || y_ra !== last_exp.ra) begin
            miscompares++;
            $display("FAIL hold: got v=%b ll=%h rl=%h ra=%h, required v=0 ll=%h rl=%h ra=%h",
                     out_valid, y_ll, y_rl, y_ra, last_exp.ll, last_exp.rl, last_exp.ra);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 11'h7FF, 4'd0);
        vectors++;
        if (out_valid !== 1'b1 || y_ll !== 11'h7FF) begin
            miscompares++;
            $display("FAIL pre_reset: got v=%b ll=%h, required v=1 ll=7ff", out_valid, y_ll);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || y_ll !== '0 || y_rl !== '0 || y_ra !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b ll=%h rl=%h ra=%h, required all 0",
                     out_valid, y_ll, y_rl, y_ra);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || y_ll !== '0 || y_rl !== '0 || y_ra !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got v=%b ll=%h rl=%h ra=%h, required all 0",
                     out_valid, y_ll, y_rl, y_ra);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || y_ll !== '0) begin
            miscompares++;
            $display("FAIL post_release_idle: got v=%b ll=%h, required v=0 ll=000", out_valid, y_ll);
        end
    endtask

    task automatic test_random();
        result_t e;
        word_t   av;
        shamt_t  sv;
        for (int i = 0; i < 1024; i++) begin
            av = word_t'($urandom);
            sv = shamt_t'($urandom_range(0, 15));
            sb_q.push_back(model(av, sv));
            drive_cycle(1'b1, av, sv);
            e = sb_q.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || y_ll !== e.ll || y_rl !== e.rl || y_ra !== e.ra) begin
                miscompares++;
                $display("FAIL random_%0d a=%h s=%0d: got v=%b ll=%h rl=%h ra=%h, required v=1 ll=%h rl=%h ra=%h",
                         i, av, sv, out_valid, y_ll, y_rl, y_ra, e.ll, e.rl, e.ra);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        drive_cycle(1'b0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
